// File: rtl/demultiplexor16_reg_if.sv
// Bus bundle for the registered 1-to-16 write demultiplexer.
// The master drives write beats; the slave returns the sixteen holding registers and status.
interface demultiplexor16_reg_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] datoInput;
  logic [3:0]      selDato;
  logic            validIn;
  logic            burstStart;
  logic [3:0]      burstLen;
  logic            clear;

  logic [BITS-1:0] datoA, datoB, datoC, datoD, datoE, datoF, datoG, datoH;
  logic [BITS-1:0] datoI, datoJ, datoK, datoL, datoM, datoN, datoO, datoP;
  logic [15:0]     strobe;
  logic            busy;
  logic            burstDone;

  modport master (
    output datoInput, selDato, validIn, burstStart, burstLen, clear,
    input  datoA, datoB, datoC, datoD, datoE, datoF, datoG, datoH,
    input  datoI, datoJ, datoK, datoL, datoM, datoN, datoO, datoP,
    input  strobe, busy, burstDone
  );

  modport slave (
    input  datoInput, selDato, validIn, burstStart, burstLen, clear,
    output datoA, datoB, datoC, datoD, datoE, datoF, datoG, datoH,
    output datoI, datoJ, datoK, datoL, datoM, datoN, datoO, datoP,
    output strobe, busy, burstDone
  );
endinterface

// File: rtl/demultiplexor16_reg.sv
// Registered 1-to-16 write demultiplexer with auto-incrementing bursts.
// Each accepted beat loads one holding register and raises a one-cycle strobe for it.
module demultiplexor16_reg #(
  parameter int BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  demultiplexor16_reg_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          r_state;
  logic [3:0]      r_ptr;
  logic [3:0]      r_rem;
  logic [BITS-1:0] r_regs [16];
  logic [15:0]     r_strobe;
  logic            r_busy;
  logic            r_done;

  // Write steering, burst sequencing and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 4'd0;
      r_rem    <= 4'd0;
      r_strobe <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      r_strobe <= 16'h0000;
      r_done   <= 1'b0;
      if (bus.clear) begin
        // clear wins over any beat and silently aborts a burst
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_ptr   <= 4'd0;
        r_rem   <= 4'd0;
        for (int k = 0; k < 16; k++) begin
          r_regs[k] <= '0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.validIn) begin
              r_regs[bus.selDato] <= bus.datoInput;
              r_strobe            <= 16'h0001 << bus.selDato;
              if (bus.burstStart) begin
                if (bus.burstLen == 4'd0) begin
                  r_done <= 1'b1;
                end else begin
                  r_ptr   <= bus.selDato + 4'd1;
                  r_rem   <= bus.burstLen;
                  r_state <= ST_BURST;
                  r_busy  <= 1'b1;
                end
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_BURST: begin
            if (bus.validIn) begin
              r_regs[r_ptr] <= bus.datoInput;
              r_strobe      <= 16'h0001 << r_ptr;
              r_ptr         <= r_ptr + 4'd1;
              r_rem         <= r_rem - 4'd1;
              if (r_rem == 4'd1) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_BURST;
              end
            end else begin
              r_state <= ST_BURST;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.datoA     = r_regs[0];
  assign bus.datoB     = r_regs[1];
  assign bus.datoC     = r_regs[2];
  assign bus.datoD     = r_regs[3];
  assign bus.datoE     = r_regs[4];
  assign bus.datoF     = r_regs[5];
  assign bus.datoG     = r_regs[6];
  assign bus.datoH     = r_regs[7];
  assign bus.datoI     = r_regs[8];
  assign bus.datoJ     = r_regs[9];
  assign bus.datoK     = r_regs[10];
  assign bus.datoL     = r_regs[11];
  assign bus.datoM     = r_regs[12];
  assign bus.datoN     = r_regs[13];
  assign bus.datoO     = r_regs[14];
  assign bus.datoP     = r_regs[15];
  assign bus.strobe    = r_strobe;
  assign bus.busy      = r_busy;
  assign bus.burstDone = r_done;

endmodule

// File: tb/tb_demultiplexor16_reg.sv
// Directed bench for demultiplexor16_reg: single writes, wrapping/full bursts,
// clear, zero-length bursts and asynchronous reset against a bench-side register model.
module tb_demultiplexor16_reg;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] exp_regs [16];
  logic [31:0] obs [16];

  demultiplexor16_reg_if #(.BITS(32)) bus ();

  demultiplexor16_reg #(.BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs[0]  = bus.datoA;
  assign obs[1]  = bus.datoB;
  assign obs[2]  = bus.datoC;
  assign obs[3]  = bus.datoD;
  assign obs[4]  = bus.datoE;
  assign obs[5]  = bus.datoF;
  assign obs[6]  = bus.datoG;
  assign obs[7]  = bus.datoH;
  assign obs[8]  = bus.datoI;
  assign obs[9]  = bus.datoJ;
  assign obs[10] = bus.datoK;
  assign obs[11] = bus.datoL;
  assign obs[12] = bus.datoM;
  assign obs[13] = bus.datoN;
  assign obs[14] = bus.datoO;
  assign obs[15] = bus.datoP;

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.datoInput  = 32'h0;
    bus.selDato    = 4'd0;
    bus.validIn    = 1'b0;
    bus.burstStart = 1'b0;
    bus.burstLen   = 4'd0;
    bus.clear      = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_regs idx=%0d got=%h exp=%h", k, obs[k], 32'h0);
      end
    end
    checks++;
    if ({bus.strobe, bus.busy, bus.burstDone} !== 18'h0) begin
      errors++;
      $display("FAIL reset_status got strobe=%h busy=%b done=%b exp all 0", bus.strobe, bus.busy, bus.burstDone);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_writes();
    for (int i = 0; i < 16; i++) begin
      bus.validIn   = 1'b1;
      bus.selDato   = 4'(i);
      bus.datoInput = 32'hA5A50000 + 32'(i);
      exp_regs[i]   = 32'hA5A50000 + 32'(i);
      tick();
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (obs[k] !== exp_regs[k]) begin
          errors++;
          $display("FAIL single_regs sel=%0d idx=%0d got=%h exp=%h", i, k, obs[k], exp_regs[k]);
        end
      end
      checks++;
      if (bus.strobe !== (16'h0001 << i)) begin
        errors++;
        $display("FAIL single_strobe sel=%0d got=%h exp=%h", i, bus.strobe, 16'h0001 << i);
      end
      bus.validIn = 1'b0;
      tick();
      checks++;
      if (bus.strobe !== 16'h0000 || bus.busy !== 1'b0 || bus.burstDone !== 1'b0) begin
        errors++;
        $display("FAIL single_idle sel=%0d got strobe=%h busy=%b done=%b exp 0", i, bus.strobe, bus.busy, bus.burstDone);
      end
    end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] beats [4];
    logic [3:0]  idx   [4];
    beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
    idx[0] = 4'd14; idx[1] = 4'd15; idx[2] = 4'd0; idx[3] = 4'd1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        bus.validIn = 1'b0;
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++;
          if (bus.busy !== 1'b1 || bus.strobe !== 16'h0000 || bus.burstDone !== 1'b0) begin
            errors++;
            $display("FAIL wrap_gap cyc=%0d got busy=%b strobe=%h done=%b exp 1/0/0", g, bus.busy, bus.strobe, bus.burstDone);
          end
        end
      end
      bus.validIn    = 1'b1;
      bus.burstStart = (b == 0);
      bus.selDato    = (b == 0) ? 4'd14 : 4'd6;
      bus.burstLen   = (b == 0) ? 4'd3 : 4'd9;
      bus.datoInput  = beats[b];
      exp_regs[idx[b]] = beats[b];
      tick();
      checks++;
      if (obs[idx[b]] !== beats[b]) begin
        errors++;
        $display("FAIL wrap_data beat=%0d got=%h exp=%h", b, obs[idx[b]], beats[b]);
      end
      checks++;
      if (bus.strobe !== (16'h0001 << idx[b])) begin
        errors++;
        $display("FAIL wrap_strobe beat=%0d got=%h exp=%h", b, bus.strobe, 16'h0001 << idx[b]);
      end
      checks++;
      if (bus.busy !== (b != 3) || bus.burstDone !== (b == 3)) begin
        errors++;
        $display("FAIL wrap_status beat=%0d got busy=%b done=%b exp busy=%b done=%b", b, bus.busy, bus.burstDone, b != 3, b == 3);
      end
    end
    bus.validIn = 1'b0;
    bus.burstStart = 1'b0;
    tick();
    checks++;
    if (bus.burstDone !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_after got done=%b busy=%b exp 0/0", bus.burstDone, bus.busy);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL wrap_regs idx=%0d got=%h exp=%h", k, obs[k], exp_regs[k]);
      end
    end
  endtask

  task automatic test_full_burst();
    for (int b = 0; b < 16; b++) begin
      bus.validIn    = 1'b1;
      bus.burstStart = (b == 0);
      bus.selDato    = (b == 0) ? 4'd0 : 4'd12;
      bus.burstLen   = 4'd15;
      bus.datoInput  = 32'(b);
      exp_regs[b]    = 32'(b);
      tick();
      checks++;
      if (bus.strobe !== (16'h0001 << b) || obs[b] !== 32'(b)) begin
        errors++;
        $display("FAIL full_beat beat=%0d got strobe=%h data=%h exp strobe=%h data=%h", b, bus.strobe, obs[b], 16'h0001 << b, 32'(b));
      end
      checks++;
      if (bus.busy !== (b != 15) || bus.burstDone !== (b == 15)) begin
        errors++;
        $display("FAIL full_status beat=%0d got busy=%b done=%b exp busy=%b done=%b", b, bus.busy, bus.burstDone, b != 15, b == 15);
      end
    end
    // Plain write issued in the same cycle burstDone is high
    bus.burstStart = 1'b0;
    bus.selDato    = 4'd5;
    bus.datoInput  = 32'hDEADBEEF;
    exp_regs[5]    = 32'hDEADBEEF;
    tick();
    checks++;
    if (bus.strobe !== 16'h0020 || bus.burstDone !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_b2b_status got strobe=%h done=%b busy=%b exp 0020/0/0", bus.strobe, bus.burstDone, bus.busy);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL full_regs idx=%0d got=%h exp=%h", k, obs[k], exp_regs[k]);
      end
    end
    bus.validIn = 1'b0;
    tick();
  endtask

  task automatic test_clear_burst();
    for (int b = 0; b < 3; b++) begin
      bus.validIn    = 1'b1;
      bus.burstStart = (b == 0);
      bus.selDato    = 4'd2;
      bus.burstLen   = 4'd5;
      bus.datoInput  = 32'hC0DE0000 + 32'(b);
      bus.clear      = (b == 2);
      if (b < 2) exp_regs[2 + b] = 32'hC0DE0000 + 32'(b);
      tick();
    end
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    bus.clear = 1'b0;
    bus.validIn = 1'b0;
    bus.burstStart = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL clear_regs idx=%0d got=%h exp=%h", k, obs[k], 32'h0);
      end
    end
    checks++;
    if (bus.strobe !== 16'h0000 || bus.burstDone !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_status got strobe=%h done=%b busy=%b exp 0/0/0", bus.strobe, bus.burstDone, bus.busy);
    end
    tick();
    bus.validIn   = 1'b1;
    bus.selDato   = 4'd9;
    bus.datoInput = 32'h12345678;
    exp_regs[9]   = 32'h12345678;
    tick();
    bus.validIn = 1'b0;
    checks++;
    if (bus.datoJ !== 32'h12345678 || bus.strobe !== 16'h0200 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_after_write got data=%h strobe=%h busy=%b exp 12345678/0200/0", bus.datoJ, bus.strobe, bus.busy);
    end
    tick();
  endtask

  task automatic test_len0();
    bus.validIn    = 1'b1;
    bus.burstStart = 1'b1;
    bus.burstLen   = 4'd0;
    bus.selDato    = 4'd7;
    bus.datoInput  = 32'h0BADF00D;
    exp_regs[7]    = 32'h0BADF00D;
    tick();
    bus.validIn    = 1'b0;
    bus.burstStart = 1'b0;
    checks++;
    if (bus.datoH !== 32'h0BADF00D || bus.strobe !== 16'h0080) begin
      errors++;
      $display("FAIL len0_write got data=%h strobe=%h exp 0badf00d/0080", bus.datoH, bus.strobe);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.burstDone !== 1'b1) begin
      errors++;
      $display("FAIL len0_status got busy=%b done=%b exp 0/1", bus.busy, bus.burstDone);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.burstDone !== 1'b0) begin
      errors++;
      $display("FAIL len0_after got busy=%b done=%b exp 0/0", bus.busy, bus.burstDone);
    end
  endtask

  task automatic test_reset_midburst();
    bus.validIn    = 1'b1;
    bus.burstStart = 1'b1;
    bus.selDato    = 4'd4;
    bus.burstLen   = 4'd8;
    bus.datoInput  = 32'h5555AAAA;
    tick();
    bus.burstStart = 1'b0;
    bus.datoInput  = 32'h6666BBBB;
    tick();
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== 32'h0) begin
        errors++;
        $display("FAIL rst_async_regs idx=%0d got=%h exp=%h", k, obs[k], 32'h0);
      end
    end
    checks++;
    if (bus.strobe !== 16'h0000 || bus.busy !== 1'b0 || bus.burstDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_status got strobe=%h busy=%b done=%b exp 0", bus.strobe, bus.busy, bus.burstDone);
    end
    tick();
    checks++;
    if (bus.datoF !== 32'h0 || bus.strobe !== 16'h0000) begin
      errors++;
      $display("FAIL rst_hold got data=%h strobe=%h exp 0/0", bus.datoF, bus.strobe);
    end
    rst = 1'b1;
    bus.selDato   = 4'd3;
    bus.datoInput = 32'hFACE0003;
    exp_regs[3]   = 32'hFACE0003;
    tick();
    bus.validIn = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[k] !== exp_regs[k]) begin
        errors++;
        $display("FAIL rst_after_regs idx=%0d got=%h exp=%h", k, obs[k], exp_regs[k]);
      end
    end
    checks++;
    if (bus.strobe !== 16'h0008 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_status got strobe=%h busy=%b exp 0008/0", bus.strobe, bus.busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_single_writes();
    test_wrap_burst();
    test_full_burst();
    test_clear_burst();
    test_len0();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demultiplexor16_reg.md
# demultiplexor16_reg

Registered 1-to-16 write demultiplexer with burst support: it steers a BITS-wide input word into one of sixteen holding registers selected by a 4-bit index. It can also auto-increment through consecutive registers for a multi-beat burst. It sits on the write-back side of the 16-entry register path, where it loads the sixteen words that the 16:1 read multiplexer selects from. Each write produces a one-cycle per-register strobe so downstream logic can detect updates.

## Interface
- BITS, 32, width of every data word
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- datoInput  input  BITS  word to write
- selDato  input  4  target register index (0=datoA … 15=datoP); also the burst start index
- validIn  input  1  a beat is present this cycle
- burstStart  input  1  qualifies a validIn beat in IDLE as the first beat of a burst
- burstLen  input  4  number of burst beats minus one (0..15 → 1..16 beats), sampled with burstStart
- clear  input  1  synchronous clear of all sixteen registers
- datoA … datoP  output  BITS each  holding registers, index 0 … 15
- strobe  output  16  one-hot, one-cycle pulse marking the register updated
- busy  output  1  high while a burst is in progress (state BURST)
- burstDone  output  1  one-cycle pulse after the final beat of a burst

## Operation
- States: IDLE, BURST. The internal pointer ptr[3:0] and the remaining-beat count rem[3:0] are registered.
- **IDLE, validIn=1, burstStart=0:** register[selDato] ← datoInput; strobe bit selDato pulses. The state stays IDLE.
- **IDLE, validIn=1, burstStart=1:** register[selDato] ← datoInput (beat 0).
  - If burstLen=0: the state stays IDLE and burstDone pulses.
  - Otherwise: ptr ← selDato+1 (mod 16), rem ← burstLen, and the state goes to BURST.
- **BURST, validIn=1:** register[ptr] ← datoInput; ptr ← ptr+1 (mod 16, 15 wraps to 0); rem ← rem−1.
  - When rem=1 (last beat): the state goes to IDLE and burstDone pulses.
  - selDato, burstStart and burstLen are ignored in BURST.
- **BURST, validIn=0:** state, ptr and rem hold. Gaps between beats are allowed and unbounded.
- **validIn=0 in IDLE:** no change. All strobe bits are 0.
- **clear=1:** all sixteen registers ← 0 and the state → IDLE.
  - strobe and burstDone stay 0 for that cycle.
  - clear has priority over a simultaneous validIn, which is dropped.
  - A burst in progress is aborted with no burstDone.
- A burst longer than 16 beats cannot be requested. A 16-beat burst writes every register exactly once.
- Registers not addressed keep their value. At most one strobe bit is set per cycle.
- **Reset (rst=0), at any time, including mid-burst:**
  - all registers, strobe, busy and burstDone → 0;
  - state → IDLE; ptr and rem → 0.
  - Any burst in progress is abandoned.

## Timing
- Write latency is 1 cycle: a beat sampled at edge N is visible on the selected output after edge N.
- strobe is registered and coincides with the first cycle the new value is visible. It lasts exactly one cycle per beat.
- busy = (state==BURST). It rises after the burst-start edge and falls after the last-beat edge.
- burstDone is high in the same cycle busy falls. For a burstLen=0 burst, busy never rises and burstDone pulses after the single beat.
- Back-to-back: a new IDLE write or burstStart is accepted on the cycle busy is low, including the cycle burstDone is high.
- No ready signal: the block accepts one beat per cycle unconditionally.

## Test plan
- **Reset:** drive rst=0 mid-operation with random register contents → all datoA…datoP=0, strobe=0, busy=0, burstDone=0 immediately, and no writes until rst=1.
- **Single writes:** for each selDato 0..15, write 0xA5A50000+index → only that register changes one cycle later, and strobe=(1<<index) for exactly one cycle.
- **Wrapping burst with gaps:** selDato=14, burstLen=3, beats 0x11,0x22,0x33,0x44 with validIn low for 2 cycles between beats 2 and 3 → datoO=0x11, datoP=0x22, datoA=0x33, datoB=0x44. busy stays high through the gap, and burstDone pulses once after 0x44.
- **Full burst:** selDato=0, burstLen=15, data 0..15 → datoA..datoP = 0..15 and 16 strobe pulses in index order. burstDone is asserted the cycle busy drops, and a plain write accepted that same cycle lands correctly.
- **Clear during a burst:** assert clear together with validIn on the third beat → all registers 0, no strobe, no burstDone, state IDLE. A subsequent single write works.
- **burstLen=0:** burstStart with selDato=7 → datoH written, busy never high, burstDone high for one cycle.
